// File: rtl/ibex_branch_resolve_ctrl.sv
// Tracks in-flight static branch predictions and checks them in order against EX resolution.
// Optional perf counters: define IBEX_BRANCH_PERF_CNT_EN.
module ibex_branch_resolve_ctrl #(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pred_valid_i,
  output logic                   pred_ready_o,
  input  logic                   pred_taken_i,
  input  logic [31:0]            pred_target_i,
  input  logic [31:0]            pred_fallthru_i,
  input  logic                   res_valid_i,
  input  logic                   res_taken_i,
  input  logic [31:0]            res_target_i,
  input  logic                   flush_i,
  output logic                   mispredict_o,
  output logic [31:0]            redirect_pc_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   err_o
`ifdef IBEX_BRANCH_PERF_CNT_EN
  ,
  output logic [CntW-1:0]        perf_branches_o,
  output logic [CntW-1:0]        perf_mispredicts_o
`endif
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {
    TRACK,
    RECOVER
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q, count;
  logic [Depth-1:0] taken_mem;
  logic [31:0]      target_mem   [Depth];
  logic [31:0]      fallthru_mem [Depth];

  logic        full, empty, in_track;
  logic        push, pop, mismatch, err_set;
  logic        head_taken;
  logic [31:0] head_target, head_fallthru;

  assign count         = wr_ptr_q - rd_ptr_q;
  assign full          = (count == PW'(Depth));
  assign empty         = (count == '0);
  assign in_track      = (state_q == TRACK);
  assign head_taken    = taken_mem[rd_ptr_q[AW-1:0]];
  assign head_target   = target_mem[rd_ptr_q[AW-1:0]];
  assign head_fallthru = fallthru_mem[rd_ptr_q[AW-1:0]];

  // Ready is held low during reset so every output reads 0 while rst_i is high.
  assign pred_ready_o = !full && in_track && !rst_i;
  assign push         = pred_valid_i && pred_ready_o;
  assign pop          = res_valid_i && in_track && !empty;
  assign err_set      = res_valid_i && in_track && empty;
  assign mismatch     = pop && ((res_taken_i != head_taken) ||
                                (res_taken_i && head_taken && (res_target_i != head_target)));
  assign count_o      = count;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TRACK:   if (mismatch) state_d = RECOVER;
      RECOVER: state_d = TRACK;
      default: state_d = TRACK;
    endcase
    if (flush_i) state_d = TRACK;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= TRACK;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush_i || mismatch) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      taken_mem[wr_ptr_q[AW-1:0]]    <= pred_taken_i;
      target_mem[wr_ptr_q[AW-1:0]]   <= pred_target_i;
      fallthru_mem[wr_ptr_q[AW-1:0]] <= pred_fallthru_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
      err_o         <= 1'b0;
    end else begin
      mispredict_o <= mismatch && !flush_i;
      if (mismatch && !flush_i) redirect_pc_o <= res_taken_i ? res_target_i : head_fallthru;
      if (err_set) err_o <= 1'b1;
    end
  end

`ifdef IBEX_BRANCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_branches_o    <= '0;
      perf_mispredicts_o <= '0;
    end else if (!flush_i) begin
      if (pop && (perf_branches_o != '1))
        perf_branches_o <= perf_branches_o + CntW'(1);
      if (mismatch && (perf_mispredicts_o != '1))
        perf_mispredicts_o <= perf_mispredicts_o + CntW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ibex_branch_resolve_ctrl.sv
// Directed self-checking bench for ibex_branch_resolve_ctrl (Depth=4).
module tb_ibex_branch_resolve_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pred_valid_i, pred_ready_o, pred_taken_i;
  logic [31:0] pred_target_i, pred_fallthru_i;
  logic        res_valid_i, res_taken_i;
  logic [31:0] res_target_i;
  logic        flush_i, mispredict_o, err_o;
  logic [31:0] redirect_pc_o;
  logic [2:0]  count_o;
`ifdef IBEX_BRANCH_PERF_CNT_EN
  logic [15:0] perf_branches_o, perf_mispredicts_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_branch_resolve_ctrl #(.Depth(4), .CntW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o), .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i), .pred_fallthru_i(pred_fallthru_i),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .flush_i(flush_i), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .count_o(count_o), .err_o(err_o)
`ifdef IBEX_BRANCH_PERF_CNT_EN
    , .perf_branches_o(perf_branches_o), .perf_mispredicts_o(perf_mispredicts_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    pred_valid_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic set_pred(input logic t, input logic [31:0] tgt, input logic [31:0] ft);
    pred_valid_i = 1'b1; pred_taken_i = t; pred_target_i = tgt; pred_fallthru_i = ft;
  endtask

  task automatic set_res(input logic t, input logic [31:0] tgt);
    res_valid_i = 1'b1; res_taken_i = t; res_target_i = tgt;
  endtask

  task automatic push_resolve(input string tag, input logic pt, input logic [31:0] ptgt,
                              input logic [31:0] pft, input logic rt, input logic [31:0] rtgt,
                              input logic exp_mis, input logic [31:0] exp_pc);
    idle(); set_pred(pt, ptgt, pft);
    tick();
    idle(); set_res(rt, rtgt);
    tick();
    chk({tag, "_mis"}, 32'(mispredict_o), 32'(exp_mis));
    if (exp_mis) chk({tag, "_pc"}, redirect_pc_o, exp_pc);
    idle();
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    pred_taken_i = 1'b0; pred_target_i = '0; pred_fallthru_i = '0;
    res_taken_i = 1'b0; res_target_i = '0;
    tick(); tick();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_mis", 32'(mispredict_o), 32'd0);
    chk("rst_pc", redirect_pc_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ready", 32'(pred_ready_o), 32'd0);
    rst_i = 1'b0;
    #1 chk("ready_after_rst", 32'(pred_ready_o), 32'd1);

    // Three correct taken predictions
    set_pred(1'b1, 32'h100, 32'h104);
    tick(); chk("t1_cnt1", 32'(count_o), 32'd1);
    tick(); chk("t1_cnt2", 32'(count_o), 32'd2);
    tick(); chk("t1_cnt3", 32'(count_o), 32'd3);
    idle(); set_res(1'b1, 32'h100);
    tick(); chk("t1_pop_cnt2", 32'(count_o), 32'd2); chk("t1_mis_a", 32'(mispredict_o), 32'd0);
    tick(); chk("t1_pop_cnt1", 32'(count_o), 32'd1); chk("t1_mis_b", 32'(mispredict_o), 32'd0);
    tick(); chk("t1_pop_cnt0", 32'(count_o), 32'd0); chk("t1_mis_c", 32'(mispredict_o), 32'd0);
    chk("t1_err", 32'(err_o), 32'd0);
    idle();

    // Predicted not-taken, resolved taken
    set_pred(1'b0, 32'h200, 32'h204);
    tick(); chk("t2_cnt1", 32'(count_o), 32'd1);
    idle(); set_res(1'b1, 32'h300);
    #1 chk("t2_no_comb_mis", 32'(mispredict_o), 32'd0);
    tick();
    chk("t2_mis", 32'(mispredict_o), 32'd1);
    chk("t2_pc", redirect_pc_o, 32'h300);
    chk("t2_cnt0", 32'(count_o), 32'd0);
    chk("t2_ready_recover", 32'(pred_ready_o), 32'd0);
    idle(); tick();
    chk("t2_mis_pulse", 32'(mispredict_o), 32'd0);
    chk("t2_ready_back", 32'(pred_ready_o), 32'd1);
    chk("t2_pc_hold", redirect_pc_o, 32'h300);

    // Predicted taken, resolved not-taken, with a same-cycle push that must be dropped
    set_pred(1'b1, 32'h80, 32'h44);
    tick(); chk("t3_cnt1", 32'(count_o), 32'd1);
    set_pred(1'b1, 32'h500, 32'h504); set_res(1'b0, 32'h0);
    tick();
    chk("t3_mis", 32'(mispredict_o), 32'd1);
    chk("t3_pc", redirect_pc_o, 32'h44);
    chk("t3_cnt0", 32'(count_o), 32'd0);
    idle(); tick();

    // Fill to full, no pop-to-ready bypass, push+pop at count 3
    set_pred(1'b1, 32'h100, 32'h104);
    tick(); tick(); tick(); tick();
    chk("t4_full_cnt", 32'(count_o), 32'd4);
    chk("t4_full_ready", 32'(pred_ready_o), 32'd0);
    pred_valid_i = 1'b0; set_res(1'b1, 32'h100);
    #1 chk("t4_no_bypass", 32'(pred_ready_o), 32'd0);
    tick(); chk("t4_cnt3", 32'(count_o), 32'd3); chk("t4_ready3", 32'(pred_ready_o), 32'd1);
    set_pred(1'b1, 32'h100, 32'h104);
    tick(); chk("t4_pushpop_cnt", 32'(count_o), 32'd3); chk("t4_pushpop_mis", 32'(mispredict_o), 32'd0);
    pred_valid_i = 1'b0;
    tick(); tick(); tick();
    chk("t4_drain", 32'(count_o), 32'd0);
    chk("t4_drain_mis", 32'(mispredict_o), 32'd0);
    idle();

    // Resolve while empty
    set_res(1'b1, 32'h100);
    tick(); chk("t5_err", 32'(err_o), 32'd1); chk("t5_mis", 32'(mispredict_o), 32'd0);
    idle(); tick(); chk("t5_err_sticky", 32'(err_o), 32'd1);

    // Mismatch coincident with flush
    set_pred(1'b0, 32'h600, 32'h604);
    tick(); chk("t6_cnt1", 32'(count_o), 32'd1);
    idle(); set_res(1'b1, 32'h700); flush_i = 1'b1;
    tick();
    chk("t6_mis", 32'(mispredict_o), 32'd0);
    chk("t6_cnt0", 32'(count_o), 32'd0);
    chk("t6_ready", 32'(pred_ready_o), 32'd1);
    chk("t6_pc_hold", redirect_pc_o, 32'h44);
    idle();
`ifdef IBEX_BRANCH_PERF_CNT_EN
    chk("perf_br_pre", 32'(perf_branches_o), 32'd10);
    chk("perf_mp_pre", 32'(perf_mispredicts_o), 32'd2);
`endif

    // Asynchronous reset mid-cycle with entries outstanding
    set_pred(1'b1, 32'h100, 32'h104);
    tick(); tick();
    idle();
    #2 rst_i = 1'b1;
    #1;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_pc", redirect_pc_o, 32'd0);
    chk("arst_mis", 32'(mispredict_o), 32'd0);
    chk("arst_ready", 32'(pred_ready_o), 32'd0);
`ifdef IBEX_BRANCH_PERF_CNT_EN
    chk("arst_perf_br", 32'(perf_branches_o), 32'd0);
    chk("arst_perf_mp", 32'(perf_mispredicts_o), 32'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    // Five resolves, two mismatching
    push_resolve("p1", 1'b1, 32'h100, 32'h104, 1'b1, 32'h100, 1'b0, 32'h0);
    push_resolve("p2", 1'b0, 32'h110, 32'h114, 1'b1, 32'h110, 1'b1, 32'h110);
    push_resolve("p3", 1'b0, 32'h120, 32'h124, 1'b0, 32'h0,   1'b0, 32'h0);
    push_resolve("p4", 1'b1, 32'h130, 32'h134, 1'b1, 32'h130, 1'b0, 32'h0);
    push_resolve("p5", 1'b1, 32'h140, 32'h144, 1'b1, 32'h150, 1'b1, 32'h150);
`ifdef IBEX_BRANCH_PERF_CNT_EN
    chk("perf_br", 32'(perf_branches_o), 32'd5);
    chk("perf_mp", 32'(perf_mispredicts_o), 32'd2);
`endif
    chk("final_cnt", 32'(count_o), 32'd0);
    chk("final_err", 32'(err_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
